// File: rtl/dma_burst_scheduler_pkg.sv
// Shared definitions for the DMA burst scheduler.
//   state_t            : scheduler FSM states
//   KMEM_*_DEFAULT     : default placement of the protected key region
//   req_onehot()       : requester index -> one-hot grant/done/err vector
package dma_burst_scheduler_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        CHECK = 3'd1,
        XFER  = 3'd2,
        DONE  = 3'd3,
        ERR   = 3'd4
    } state_t;

    localparam logic [15:0] KMEM_BASE_DEFAULT = 16'h6A00;
    localparam logic [15:0] KMEM_SIZE_DEFAULT = 16'h001F;

    function automatic logic [1:0] req_onehot(input logic idx);
        return idx ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/dma_burst_scheduler_if.sv
// Requester + DMA bus bundle of the burst scheduler.
//   req[1:0], req_addr0/1, req_len0/1 : burst requests (len in 16-bit words)
//   kill                              : synchronous abort
//   dma_ready                         : memory accepted the current word
//   dma_en, dma_addr, grant           : DMA bus access driven by the scheduler
//   done, err, violation              : one-cycle completion / rejection pulses
// modport master : the scheduler (owns the DMA bus)
// modport slave  : requesters and memory surrounding it
interface dma_burst_scheduler_if;

    logic [1:0]  req;
    logic [15:0] req_addr0;
    logic [15:0] req_addr1;
    logic [7:0]  req_len0;
    logic [7:0]  req_len1;
    logic        kill;
    logic        dma_ready;
    logic        dma_en;
    logic [15:0] dma_addr;
    logic [1:0]  grant;
    logic [1:0]  done;
    logic [1:0]  err;
    logic        violation;

    modport master (
        input  req, req_addr0, req_addr1, req_len0, req_len1, kill, dma_ready,
        output dma_en, dma_addr, grant, done, err, violation
    );

    modport slave (
        output req, req_addr0, req_addr1, req_len0, req_len1, kill, dma_ready,
        input  dma_en, dma_addr, grant, done, err, violation
    );

endinterface

// File: rtl/dma_range_check.sv
// Combinational legality check of a burst.
//   start   : first byte address of the burst
//   len     : burst length in 16-bit words
//   bad     : burst must be rejected (zero length, address wrap or key overlap)
//   overlap : burst touches [KMEM_BASE, KMEM_BASE+KMEM_SIZE)
module dma_range_check
    import dma_burst_scheduler_pkg::*;
#(
    parameter logic [15:0] KMEM_BASE = KMEM_BASE_DEFAULT,
    parameter logic [15:0] KMEM_SIZE = KMEM_SIZE_DEFAULT
) (
    input  logic [15:0] start,
    input  logic [7:0]  len,
    output logic        bad,
    output logic        overlap
);

    // Exclusive end of the key region, kept in 17 bits so a region ending at
    // the top of the address space does not fold back to zero.
    localparam logic [16:0] KMEM_LIMIT = {1'b0, KMEM_BASE} + {1'b0, KMEM_SIZE};

    logic        len_zero;
    logic [7:0]  len_m1;
    logic [16:0] last_addr;
    logic        wrap;

    assign len_zero  = (len == 8'd0);
    assign len_m1    = len - 8'd1;
    // Byte address of the last word; bit 16 set means the burst wraps.
    assign last_addr = {1'b0, start} + {8'd0, len_m1, 1'b0};
    assign wrap      = last_addr[16];

    // A zero-length burst is rejected on its own; its wrapped last_addr is
    // meaningless and must not be reported as a key-region hit.
    assign overlap = !len_zero
                  && ({1'b0, start} < KMEM_LIMIT)
                  && (last_addr >= {1'b0, KMEM_BASE});

    assign bad = len_zero || wrap || overlap;

endmodule

// File: rtl/dma_burst_scheduler.sv
// Two-requester DMA burst scheduler with key-region protection.
//   clk   : system clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : requester/DMA bundle (master side), see dma_burst_scheduler_if
// A request is latched in IDLE, checked for one cycle, then either streamed
// word by word on the DMA bus (XFER -> DONE) or rejected (ERR). Arbitration
// is round-robin between the two requesters.
module dma_burst_scheduler
    import dma_burst_scheduler_pkg::*;
#(
    parameter logic [15:0] KMEM_BASE = KMEM_BASE_DEFAULT,
    parameter logic [15:0] KMEM_SIZE = KMEM_SIZE_DEFAULT
) (
    input  logic                  clk,
    input  logic                  rst_n,
    dma_burst_scheduler_if.master bus
);

    state_t      state_reg;
    logic        rr_ptr_reg;     // requester with priority on a tie
    logic        sel_reg;        // requester owning the current burst
    logic [15:0] start_reg;
    logic [7:0]  len_reg;
    logic [15:0] addr_reg;
    logic [7:0]  count_reg;      // words still to be accepted
    logic        dma_en_reg;
    logic [1:0]  grant_reg;
    logic [1:0]  done_reg;
    logic [1:0]  err_reg;
    logic        violation_reg;

    logic        chk_bad;
    logic        chk_overlap;
    logic        pick_next;

    // A lone request wins outright; a tie goes to the round-robin pointer.
    always_comb begin
        pick_next = rr_ptr_reg;
        if (bus.req == 2'b01) begin
            pick_next = 1'b0;
        end else if (bus.req == 2'b10) begin
            pick_next = 1'b1;
        end
    end

    dma_range_check #(
        .KMEM_BASE (KMEM_BASE),
        .KMEM_SIZE (KMEM_SIZE)
    ) u_range_check (
        .start   (start_reg),
        .len     (len_reg),
        .bad     (chk_bad),
        .overlap (chk_overlap)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= IDLE;
            rr_ptr_reg    <= 1'b0;
            sel_reg       <= 1'b0;
            start_reg     <= 16'h0000;
            len_reg       <= 8'd0;
            addr_reg      <= 16'h0000;
            count_reg     <= 8'd0;
            dma_en_reg    <= 1'b0;
            grant_reg     <= 2'b00;
            done_reg      <= 2'b00;
            err_reg       <= 2'b00;
            violation_reg <= 1'b0;
        end else begin
            // Status outputs are single-cycle pulses.
            done_reg      <= 2'b00;
            err_reg       <= 2'b00;
            violation_reg <= 1'b0;

            if (bus.kill) begin
                // Abort wins over everything and blocks new arbitration;
                // the round-robin pointer keeps its value.
                state_reg  <= IDLE;
                dma_en_reg <= 1'b0;
                grant_reg  <= 2'b00;
            end else begin
                case (state_reg)
                    IDLE: begin
                        if (|bus.req) begin
                            sel_reg   <= pick_next;
                            start_reg <= pick_next ? bus.req_addr1 : bus.req_addr0;
                            len_reg   <= pick_next ? bus.req_len1  : bus.req_len0;
                            state_reg <= CHECK;
                        end
                    end
                    CHECK: begin
                        if (chk_bad) begin
                            state_reg     <= ERR;
                            err_reg       <= req_onehot(sel_reg);
                            violation_reg <= chk_overlap;
                        end else begin
                            state_reg  <= XFER;
                            dma_en_reg <= 1'b1;
                            grant_reg  <= req_onehot(sel_reg);
                            addr_reg   <= start_reg;
                            count_reg  <= len_reg;
                        end
                    end
                    XFER: begin
                        if (bus.dma_ready) begin
                            addr_reg  <= addr_reg + 16'd2;
                            count_reg <= count_reg - 8'd1;
                            if (count_reg == 8'd1) begin
                                state_reg  <= DONE;
                                dma_en_reg <= 1'b0;
                                grant_reg  <= 2'b00;
                                done_reg   <= req_onehot(sel_reg);
                            end
                        end
                    end
                    DONE, ERR: begin
                        rr_ptr_reg <= ~sel_reg;
                        state_reg  <= IDLE;
                    end
                    default: begin
                        state_reg <= IDLE;
                    end
                endcase
            end
        end
    end

    assign bus.dma_en    = dma_en_reg;
    assign bus.dma_addr  = addr_reg;
    assign bus.grant     = grant_reg;
    assign bus.done      = done_reg;
    assign bus.err       = err_reg;
    assign bus.violation = violation_reg;

endmodule

// File: tb/tb_dma_burst_scheduler.sv
// Self-checking bench for dma_burst_scheduler: a table of single bursts,
// hand-written kill / reset / round-robin / stall sequences, and random
// bursts checked against a plain-arithmetic reference model.
module tb_dma_burst_scheduler;

    localparam int KB = 'h6A00;
    localparam int KS = 'h001F;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;
    int   tb_rr;      // model: requester with priority on a tie

    dma_burst_scheduler_if bus();

    dma_burst_scheduler #(
        .KMEM_BASE (16'h6A00),
        .KMEM_SIZE (16'h001F)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Reference legality: a burst covers bytes [a, a + 2*len - 1]; it is
    // refused when empty, when its last word lies beyond 16'hFFFF, or when
    // it touches the key region.
    function automatic void ref_check(input logic [15:0] a, input logic [7:0] l,
                                      output bit ok, output bit viol);
        int s;
        int e;
        s    = int'(a);
        e    = s + 2 * (int'(l) - 1);
        viol = (l != 8'd0) && (s < KB + KS) && (e >= KB);
        ok   = (l != 8'd0) && !viol && (e <= 65535);
    endfunction

    function automatic logic [15:0] rand_addr();
        case ($urandom_range(0, 2))
            0:       return 16'h69C0 + 16'($urandom_range(0, 127));
            1:       return 16'hFFE0 + 16'($urandom_range(0, 31));
            default: return 16'($urandom());
        endcase
    endfunction

    // Runs one burst from IDLE and checks it cycle by cycle.
    // rmode: 0 = dma_ready always 1, 1 = random, 2 = stall on 2nd XFER cycle.
    task automatic run_burst(input string tag, input logic [1:0] rq,
                             input logic [15:0] a0, input logic [7:0] l0,
                             input logic [15:0] a1, input logic [7:0] l1,
                             input int who, input bit ok, input bit viol, input int rmode);
        logic [15:0] a;
        logic [7:0]  l;
        logic [1:0]  oh;
        int          k;
        int          cyc;
        bit          r;
        a  = (who != 0) ? a1 : a0;
        l  = (who != 0) ? l1 : l0;
        oh = (who != 0) ? 2'b10 : 2'b01;
        $display("burst %-12s req=%b who=%0d addr=%h len=%0d ok=%0d viol=%0d",
                 tag, rq, who, a, l, ok, viol);
        bus.req       = rq;
        bus.req_addr0 = a0;
        bus.req_len0  = l0;
        bus.req_addr1 = a1;
        bus.req_len1  = l1;
        bus.dma_ready = 1'b1;
        tick();
        // Latched already: dropping/scrambling the request must not matter.
        bus.req       = 2'b00;
        bus.req_addr0 = ~a0;
        bus.req_addr1 = ~a1;
        bus.req_len0  = 8'd1;
        bus.req_len1  = 8'd1;
        chk({tag, " c1 dma_en"}, 32'(bus.dma_en), 0);
        chk({tag, " c1 err"}, 32'(bus.err), 0);
        tick();
        if (!ok) begin
            chk({tag, " err"}, 32'(bus.err), 32'(oh));
            chk({tag, " violation"}, 32'(bus.violation), 32'(viol));
            chk({tag, " rej dma_en"}, 32'(bus.dma_en), 0);
            chk({tag, " rej grant"}, 32'(bus.grant), 0);
            tick();
            chk({tag, " err end"}, 32'(bus.err), 0);
            chk({tag, " viol end"}, 32'(bus.violation), 0);
            chk({tag, " rej dma_en2"}, 32'(bus.dma_en), 0);
            tb_rr = (who != 0) ? 0 : 1;
            return;
        end
        k   = 0;
        cyc = 0;
        while (k < int'(l) && cyc < 8 * int'(l) + 32) begin
            chk({tag, " dma_en"}, 32'(bus.dma_en), 1);
            chk({tag, " grant"}, 32'(bus.grant), 32'(oh));
            chk({tag, " dma_addr"}, 32'(bus.dma_addr), 32'(a + 16'(2 * k)));
            chk({tag, " early done"}, 32'(bus.done), 0);
            if (rmode == 0)      r = 1'b1;
            else if (rmode == 2) r = (cyc != 1);
            else                 r = ($urandom_range(0, 3) != 0);
            bus.dma_ready = r;
            tick();
            if (r) k++;
            cyc++;
        end
        bus.dma_ready = 1'b1;
        chk({tag, " words accepted"}, 32'(k), 32'(l));
        chk({tag, " done"}, 32'(bus.done), 32'(oh));
        chk({tag, " done dma_en"}, 32'(bus.dma_en), 0);
        chk({tag, " done grant"}, 32'(bus.grant), 0);
        tick();
        chk({tag, " done end"}, 32'(bus.done), 0);
        tb_rr = (who != 0) ? 0 : 1;
    endtask

    typedef struct {
        logic [1:0]  rq;
        logic [15:0] a0;
        logic [7:0]  l0;
        logic [15:0] a1;
        logic [7:0]  l1;
        int          who;
        bit          ok;
        bit          viol;
    } vec_t;

    vec_t        vecs[12];
    logic [1:0]  rq;
    logic [15:0] ra0, ra1;
    logic [7:0]  rl0, rl1;
    int          who, n, w, exp_who;
    bit          ok, viol;

    initial begin
        checks = 0;
        errors = 0;
        tb_rr  = 0;
        // Expected outcomes worked out by hand; the round-robin winner of the
        // tie rows follows from the requesters served by the rows above.
        vecs[0]  = '{2'b01, 16'h2000, 8'd4,   16'h0000, 8'd0, 0, 1'b1, 1'b0}; // basic
        vecs[1]  = '{2'b01, 16'h69F0, 8'd16,  16'h0000, 8'd0, 0, 1'b0, 1'b1}; // overlap
        vecs[2]  = '{2'b10, 16'h0000, 8'd0,   16'hFFFE, 8'd2, 1, 1'b0, 1'b0}; // wrap
        vecs[3]  = '{2'b01, 16'h1000, 8'd0,   16'h0000, 8'd0, 0, 1'b0, 1'b0}; // len 0
        vecs[4]  = '{2'b10, 16'h0000, 8'd0,   16'h69F0, 8'd8, 1, 1'b1, 1'b0}; // ends 69FE
        vecs[5]  = '{2'b01, 16'h69FE, 8'd2,   16'h0000, 8'd0, 0, 1'b0, 1'b1}; // ends at base
        vecs[6]  = '{2'b10, 16'h0000, 8'd0,   16'h6A1F, 8'd1, 1, 1'b1, 1'b0}; // starts at limit
        vecs[7]  = '{2'b01, 16'h6A1E, 8'd1,   16'h0000, 8'd0, 0, 1'b0, 1'b1}; // last key byte
        vecs[8]  = '{2'b11, 16'h3000, 8'd2,   16'h4000, 8'd3, 1, 1'b1, 1'b0}; // tie, rr=1
        vecs[9]  = '{2'b11, 16'h3000, 8'd2,   16'h4000, 8'd3, 0, 1'b1, 1'b0}; // tie, rr=0
        vecs[10] = '{2'b10, 16'h0000, 8'd0,   16'hFFFC, 8'd2, 1, 1'b1, 1'b0}; // ends FFFE
        vecs[11] = '{2'b01, 16'hFE00, 8'd255, 16'h0000, 8'd0, 0, 1'b1, 1'b0}; // max len

        rst_n         = 1'b0;
        bus.req       = 2'b00;
        bus.req_addr0 = 16'h0000;
        bus.req_addr1 = 16'h0000;
        bus.req_len0  = 8'd0;
        bus.req_len1  = 8'd0;
        bus.kill      = 1'b0;
        bus.dma_ready = 1'b1;
        #3;
        chk("reset dma_en", 32'(bus.dma_en), 0);
        chk("reset dma_addr", 32'(bus.dma_addr), 0);
        chk("reset grant", 32'(bus.grant), 0);
        chk("reset done", 32'(bus.done), 0);
        chk("reset err", 32'(bus.err), 0);
        chk("reset violation", 32'(bus.violation), 0);
        tick();
        tick();
        rst_n = 1'b1;

        for (int i = 0; i < 12; i++) begin
            run_burst($sformatf("vec%0d", i), vecs[i].rq, vecs[i].a0, vecs[i].l0,
                      vecs[i].a1, vecs[i].l1, vecs[i].who, vecs[i].ok, vecs[i].viol, 0);
        end

        // dma_ready 1,0,1: address must hold over the stall cycle.
        run_burst("stall", 2'b01, 16'h1000, 8'd4, 16'h0000, 8'd0, 0, 1'b1, 1'b0, 2);

        // kill mid-XFER: bus released at once, no pulses, no arbitration while
        // kill is held, round-robin pointer untouched.
        w             = tb_rr;
        $display("burst kill         req=11 who=%0d", w);
        bus.req       = 2'b11;
        bus.req_addr0 = 16'h2200;
        bus.req_len0  = 8'd8;
        bus.req_addr1 = 16'h5200;
        bus.req_len1  = 8'd8;
        bus.dma_ready = 1'b1;
        tick();
        tick();
        chk("kill pre dma_en", 32'(bus.dma_en), 1);
        tick();
        bus.kill = 1'b1;
        tick();
        chk("kill dma_en", 32'(bus.dma_en), 0);
        chk("kill grant", 32'(bus.grant), 0);
        chk("kill done", 32'(bus.done), 0);
        chk("kill err", 32'(bus.err), 0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("kill hold dma_en", 32'(bus.dma_en), 0);
            chk("kill hold done", 32'(bus.done), 0);
        end
        bus.kill = 1'b0;
        bus.req  = 2'b00;
        run_burst("after kill", 2'b11, 16'h2300, 8'd3, 16'h5300, 8'd3, w, 1'b1, 1'b0, 0);

        // reset mid-XFER: outputs clear without waiting for a clock edge.
        $display("burst reset        req=01 who=0");
        bus.req       = 2'b01;
        bus.req_addr0 = 16'h2400;
        bus.req_len0  = 8'd8;
        tick();
        tick();
        tick();
        chk("rst pre dma_en", 32'(bus.dma_en), 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst async dma_en", 32'(bus.dma_en), 0);
        chk("rst async grant", 32'(bus.grant), 0);
        chk("rst async dma_addr", 32'(bus.dma_addr), 0);
        tick();
        bus.req = 2'b00;
        tick();
        rst_n = 1'b1;
        tb_rr = 0;
        for (int i = 0; i < 2; i++) begin
            tick();
            chk("rst after done", 32'(bus.done), 0);
            chk("rst after err", 32'(bus.err), 0);
        end

        // Both requesters held high: service alternates 0,1,0,1 from reset.
        bus.req_addr0 = 16'h2100;
        bus.req_len0  = 8'd2;
        bus.req_addr1 = 16'h5100;
        bus.req_len1  = 8'd3;
        bus.req       = 2'b11;
        for (int b = 0; b < 4; b++) begin
            exp_who = b % 2;
            $display("burst rr%0d          req=11 who=%0d", b, exp_who);
            n = 0;
            while (bus.dma_en !== 1'b1 && n < 10) begin
                tick();
                n++;
            end
            chk("rr grant", 32'(bus.grant), (exp_who != 0) ? 2 : 1);
            chk("rr dma_addr", 32'(bus.dma_addr), (exp_who != 0) ? 'h5100 : 'h2100);
            n = 0;
            while (bus.done === 2'b00 && n < 10) begin
                tick();
                n++;
            end
            chk("rr done", 32'(bus.done), (exp_who != 0) ? 2 : 1);
            tick();
        end
        bus.req = 2'b00;
        tick();
        tick();
        tb_rr = 0;

        // Random bursts against the reference model.
        for (int t = 0; t < 40; t++) begin
            rq  = 2'($urandom_range(1, 3));
            ra0 = rand_addr();
            ra1 = rand_addr();
            rl0 = 8'($urandom_range(0, 12));
            rl1 = 8'($urandom_range(0, 12));
            if (rq == 2'b11)      who = tb_rr;
            else if (rq == 2'b10) who = 1;
            else                  who = 0;
            ref_check((who != 0) ? ra1 : ra0, (who != 0) ? rl1 : rl0, ok, viol);
            run_burst($sformatf("rnd%0d", t), rq, ra0, rl0, ra1, rl1, who, ok, viol, 1);
            n = $urandom_range(0, 2);
            for (int g = 0; g < n; g++) tick();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/dma_burst_scheduler.md
DMA_BURST_SCHEDULER -- requirements
Module: dma_burst_scheduler

Interface
REQ-001 SHALL have parameter KMEM_BASE, default 16'h6A00, meaning the first byte address of the protected key region.
REQ-002 SHALL have parameter KMEM_SIZE, default 16'h001F, meaning the protected region length in bytes; the region is [KMEM_BASE, KMEM_BASE+KMEM_SIZE).
REQ-003 SHALL have port clk  input  1  single system clock; all state changes on its rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port req  input  2  per-requester burst request; bit i belongs to requester i.
REQ-006 SHALL have port req_addr0, req_addr1  input  16 each  burst start byte address for requester 0 and requester 1.
REQ-007 SHALL have port req_len0, req_len1  input  8 each  burst length in 16-bit words for requester 0 and requester 1.
REQ-008 SHALL have port kill  input  1  synchronous abort from the root-of-trust monitor.
REQ-009 SHALL have port dma_ready  input  1  memory accepted the current dma_addr word this cycle.
REQ-010 SHALL have port dma_en  output  1  DMA bus access active.
REQ-011 SHALL have port dma_addr  output  16  DMA bus word address.
REQ-012 SHALL have port grant  output  2  one-hot; identifies the requester owning the bus.
REQ-013 SHALL have port done  output  2  one-cycle pulse when a burst completes.
REQ-014 SHALL have port err  output  2  one-cycle pulse when a burst is rejected.
REQ-015 SHALL have port violation  output  1  one-cycle pulse for every rejected burst caused by a key-region overlap.

Function
REQ-016 SHALL implement the states IDLE, CHECK, XFER, DONE and ERR.
REQ-017 In IDLE, SHALL select one requester when any req bit is high, latch that requester's addr/len, and enter CHECK on the next cycle.
REQ-018 SHALL arbitrate round-robin: the round-robin pointer gives priority to the requester not most recently served; after reset, requester 0 has priority.
REQ-019 CHECK SHALL last exactly one cycle and compute end = start + 2*(len-1) in 17 bits.
REQ-020 CHECK SHALL go to ERR if len==0, if end[16]==1 (address wrap), or if start < KMEM_BASE+KMEM_SIZE and end >= KMEM_BASE; otherwise CHECK SHALL go to XFER.
REQ-021 In XFER, grant[i] and dma_en SHALL be 1 and dma_addr SHALL equal the current address.
REQ-022 In XFER, the current address SHALL increment by 2 and the remaining count SHALL decrement on each cycle with dma_ready=1; when dma_ready=0, dma_addr SHALL hold.
REQ-023 The last word accepted in XFER (count==1 and dma_ready=1) SHALL move the block to DONE, with dma_en=0 in DONE.
REQ-024 DONE SHALL pulse done[i] for one cycle, update the round-robin pointer, and return to IDLE.
REQ-025 ERR SHALL pulse err[i] for one cycle, pulse violation only for a region overlap (not for len==0 or wrap-only failures), update the round-robin pointer, and return to IDLE; grant and dma_en SHALL stay 0 for a rejected burst.
REQ-026 After latching in IDLE, req is ignored; a req drop mid-burst SHALL NOT shorten the burst.
REQ-027 kill=1 in any state SHALL force IDLE on the next edge with dma_en, grant, done and err at 0, SHALL leave the round-robin pointer unchanged, and SHALL prevent any arbitration while kill=1.
REQ-028 Minimum burst latency SHALL be req high at cycle 0, first dma_en at cycle 2, and done at cycle 2+len when dma_ready is held at 1.
REQ-029 When both req bits are high in IDLE, the block SHALL grant exactly one requester, chosen per the round-robin pointer.

Reset
REQ-030 rst_n=0 SHALL immediately set state=IDLE, dma_en=0, dma_addr=16'h0000, grant=0, done=0, err=0, violation=0 and the round-robin pointer=0, independent of clk.
REQ-031 Reset asserted mid-XFER SHALL abort the burst with no done or err pulse afterward.

Structure
REQ-032 A shared package/include SHALL hold the state encodings and the KMEM_BASE/KMEM_SIZE defaults.
REQ-033 The range/overlap/wrap check SHALL be a sub-module dma_range_check (combinational; inputs start, len; outputs bad, overlap).

Verification
REQ-034 The bench SHALL drive req0 with addr 16'h2000, len 4, dma_ready=1 and check dma_addr 2000,2002,2004,2006 on cycles 2-5 and done[0] on cycle 6.
REQ-035 The bench SHALL drive req0 with addr 16'h69F0, len 16 (overlaps 6A00) and check err[0] and violation pulsed with dma_en never high.
REQ-036 The bench SHALL drive req0 and req1 high simultaneously, repeatedly, and check grant order 0,1,0,1.
REQ-037 The bench SHALL drive req1 with addr 16'hFFFE, len 2 (wrap) and check err[1]=1 and violation=0.
REQ-038 The bench SHALL assert kill mid-XFER, and separately rst_n=0 mid-XFER, and check dma_en=0 next edge (immediately for reset), no done, and a subsequent request still served.
REQ-039 The bench SHALL toggle dma_ready 1,0,1 mid-burst and check dma_addr holds during the stall cycle.
